// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the one-hot sequence FSM and its stimulus generator:
// state encodings, controller states and the per-state stimulus vectors.
package fsm_seq_pkg;

    localparam logic [3:0] S0 = 4'b1000;
    localparam logic [3:0] S1 = 4'b0100;
    localparam logic [3:0] S2 = 4'b0010;
    localparam logic [3:0] S3 = 4'b0001;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_HOLD = 2'd1,
        CTRL_STEP = 2'd2,
        CTRL_DONE = 2'd3
    } ctrl_e;

    // Indexed by the one-hot bit position, so entry [3] belongs to S0.
    // Each hold vector is chosen so that it never meets its own state's advance condition.
    localparam logic [3:0][2:0] HOLD_VEC = {3'b000, 3'b110, 3'b011, 3'b011};
    localparam logic [3:0][2:0] ADV_VEC  = {3'b010, 3'b011, 3'b101, 3'b110};

    function automatic logic is_onehot(input logic [3:0] s);
        return (s != 4'b0000) && ((s & (s - 4'b0001)) == 4'b0000);
    endfunction

    function automatic logic [3:0] rot_right(input logic [3:0] s);
        return {s[0], s[3:1]};
    endfunction

endpackage

// File: rtl/fsm_stim_vec.sv
// Decodes the {A6,X3,I3} stimulus vector from the shadow state and the
// step flag: hold vector when idling in a state, advance vector when stepping.
module fsm_stim_vec
    import fsm_seq_pkg::*;
(
    input  logic [3:0] i_shadow,
    input  logic       i_step,
    output logic [2:0] o_vec
);

    always_comb begin
        o_vec = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (i_shadow[i]) begin
                o_vec = o_vec | (i_step ? ADV_VEC[i] : HOLD_VEC[i]);
            end
        end
    end

endmodule

// File: rtl/fsm_stim_gen.sv
// Walks the one-hot sequence FSM to a requested target state, dwelling a
// programmable number of cycles in each state before its advance cycle.
module fsm_stim_gen
    import fsm_seq_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_target,
    input  logic [DWELL_W-1:0] req_dwell,
    input  logic               abort,
    output logic               A6,
    output logic               X3,
    output logic               I3,
    output logic [3:0]         shadow_state,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // state     | meaning
    // CTRL_IDLE | no walk; hold vector keeps the FSM parked, accepts requests
    // CTRL_HOLD | dwelling in current state, counter running down to 1
    // CTRL_STEP | advance vector for one cycle; shadow rotates at its edge
    // CTRL_DONE | arrived at target; done pulse, then back to idle

    ctrl_e               r_ctrl;
    ctrl_e               w_ctrl_nxt;
    logic [3:0]          r_shadow;
    logic [3:0]          w_shadow_nxt;
    logic [3:0]          r_target;
    logic [3:0]          w_target_nxt;
    logic [DWELL_W-1:0]  r_dwell;
    logic [DWELL_W-1:0]  w_dwell_nxt;
    logic [DWELL_W-1:0]  r_cnt;
    logic [DWELL_W-1:0]  w_cnt_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic [3:0]          w_shadow_rot;
    logic [2:0]          w_vec;

    assign w_shadow_rot = rot_right(r_shadow);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ctrl   <= CTRL_IDLE;
            r_shadow <= S0;
            r_target <= S0;
            r_dwell  <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ctrl   <= w_ctrl_nxt;
            r_shadow <= w_shadow_nxt;
            r_target <= w_target_nxt;
            r_dwell  <= w_dwell_nxt;
            r_cnt    <= w_cnt_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_ctrl_nxt   = r_ctrl;
        w_shadow_nxt = r_shadow;
        w_target_nxt = r_target;
        w_dwell_nxt  = r_dwell;
        w_cnt_nxt    = r_cnt;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        unique case (r_ctrl)
            CTRL_IDLE: begin
                if (req_valid) begin
                    w_target_nxt = req_target;
                    w_dwell_nxt  = req_dwell;
                    if (!is_onehot(req_target)) begin
                        w_err_nxt = 1'b1;
                    end else if (req_target == r_shadow) begin
                        w_ctrl_nxt = CTRL_DONE;
                        w_done_nxt = 1'b1;
                    end else if (req_dwell != '0) begin
                        w_ctrl_nxt = CTRL_HOLD;
                        w_cnt_nxt  = req_dwell;
                    end else begin
                        w_ctrl_nxt = CTRL_STEP;
                    end
                end
            end
            CTRL_HOLD: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (abort) begin
                    w_ctrl_nxt = CTRL_IDLE;
                end else if (r_cnt == DWELL_W'(1)) begin
                    w_ctrl_nxt = CTRL_STEP;
                end
            end
            CTRL_STEP: begin
                // The FSM samples the advance vector at this edge regardless of abort.
                w_shadow_nxt = w_shadow_rot;
                if (abort) begin
                    w_ctrl_nxt = CTRL_IDLE;
                end else if (w_shadow_rot == r_target) begin
                    w_ctrl_nxt = CTRL_DONE;
                    w_done_nxt = 1'b1;
                end else if (r_dwell != '0) begin
                    w_ctrl_nxt = CTRL_HOLD;
                    w_cnt_nxt  = r_dwell;
                end else begin
                    w_ctrl_nxt = CTRL_STEP;
                end
            end
            CTRL_DONE: begin
                w_ctrl_nxt = CTRL_IDLE;
            end
            default: begin
                w_ctrl_nxt = CTRL_IDLE;
            end
        endcase
    end

    fsm_stim_vec u_vec (
        .i_shadow (r_shadow),
        .i_step   (r_ctrl == CTRL_STEP),
        .o_vec    (w_vec)
    );

    assign {A6, X3, I3}  = w_vec;
    assign shadow_state  = r_shadow;
    assign busy          = (r_ctrl == CTRL_HOLD) || (r_ctrl == CTRL_STEP);
    assign req_ready     = (r_ctrl == CTRL_IDLE);
    assign done          = r_done;
    assign err           = r_err;

endmodule
